// File: rtl/cvxif_pkg.sv
// Shared CV-X-IF types for the issue arbiter: payload structs, the
// owner-table entry and the arbiter state encoding.
package cvxif_pkg;

  localparam int unsigned XNumReq     = 2;
  localparam int unsigned XIdWidth    = 3;
  localparam int unsigned XDataWidth  = 32;
  localparam int unsigned XOwnerWidth = (XNumReq > 1) ? $clog2(XNumReq) : 1;
  localparam int unsigned XNumIds     = 2 ** XIdWidth;

  typedef logic [XIdWidth-1:0] x_id_t;

  typedef struct packed {
    logic [31:0]                 instr;
    x_id_t                       id;
    logic [1:0][XDataWidth-1:0]  rs;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
  } x_issue_resp_t;

  typedef struct packed {
    x_id_t                  id;
    logic [XDataWidth-1:0]  data;
    logic [4:0]             rd;
    logic                   we;
  } x_result_t;

  typedef struct packed {
    logic                    valid;
    logic [XOwnerWidth-1:0]  owner;
  } owner_entry_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Round-robin successor of a grant index, wrapping at n-1.
  function automatic logic [XOwnerWidth-1:0] rr_next(input logic [XOwnerWidth-1:0] g,
                                                     input int unsigned n);
    if (32'(g) == n - 1) return '0;
    return g + 1'b1;
  endfunction

endpackage

// File: rtl/cvxif_issue_arbiter_if.sv
// Bundle of requester-side and coprocessor-side CV-X-IF signals around the
// issue arbiter. The slave modport is the arbiter; master is the environment
// (cores plus coprocessor). Suffixes are from the arbiter's point of view.
interface cvxif_issue_arbiter_if
  import cvxif_pkg::*;
#(
  parameter int unsigned NumReq = XNumReq
) ();

  logic          [NumReq-1:0]               req_issue_valid_i;
  logic          [NumReq-1:0]               req_issue_ready_o;
  x_issue_req_t  [NumReq-1:0]               req_issue_req_i;
  x_issue_resp_t [NumReq-1:0]               req_issue_resp_o;
  logic          [NumReq-1:0]               req_kill_valid_i;
  logic          [NumReq-1:0][XIdWidth-1:0] req_kill_id_i;
  logic          [NumReq-1:0]               req_result_valid_o;
  logic          [NumReq-1:0]               req_result_ready_i;
  x_result_t                                req_result_o;

  logic          cop_issue_valid_o;
  logic          cop_issue_ready_i;
  x_issue_req_t  cop_issue_req_o;
  x_issue_resp_t cop_issue_resp_i;
  logic          cop_result_valid_i;
  logic          cop_result_ready_o;
  x_result_t     cop_result_i;

  modport slave (
    input  req_issue_valid_i, req_issue_req_i, req_kill_valid_i, req_kill_id_i,
           req_result_ready_i, cop_issue_ready_i, cop_issue_resp_i,
           cop_result_valid_i, cop_result_i,
    output req_issue_ready_o, req_issue_resp_o, req_result_valid_o, req_result_o,
           cop_issue_valid_o, cop_issue_req_o, cop_result_ready_o
  );

  modport master (
    output req_issue_valid_i, req_issue_req_i, req_kill_valid_i, req_kill_id_i,
           req_result_ready_i, cop_issue_ready_i, cop_issue_resp_i,
           cop_result_valid_i, cop_result_i,
    input  req_issue_ready_o, req_issue_resp_o, req_result_valid_o, req_result_o,
           cop_issue_valid_o, cop_issue_req_o, cop_result_ready_o
  );

endinterface

// File: rtl/cvxif_owner_table.sv
// ID-indexed owner table: one set port, NumClr clear ports and a lookup port.
// Clears are applied before the set, so a same-cycle release and re-issue of
// one ID leaves the entry owned by the new issuer.
module cvxif_owner_table
  import cvxif_pkg::*;
#(
  parameter int unsigned NumClr = XNumReq + 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             set_en_i,
  input  x_id_t                            set_id_i,
  input  logic [XOwnerWidth-1:0]           set_owner_i,
  input  logic [NumClr-1:0]                clr_en_i,
  input  x_id_t [NumClr-1:0]               clr_id_i,
  input  x_id_t                            lookup_id_i,
  output owner_entry_t                     lookup_o,
  output owner_entry_t [XNumIds-1:0]       table_o
);

  owner_entry_t [XNumIds-1:0] tbl_q, tbl_d;

  // Next table contents: all clears first, then the optional set.
  always_comb begin
    tbl_d = tbl_q;
    for (int c = 0; c < NumClr; c++) begin
      if (clr_en_i[c]) tbl_d[clr_id_i[c]] = '0;
    end
    if (set_en_i) begin
      tbl_d[set_id_i].valid = 1'b1;
      tbl_d[set_id_i].owner = set_owner_i;
    end
  end

  // Table storage; every entry starts invalid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tbl_q <= '0;
    else         tbl_q <= tbl_d;
  end

  assign lookup_o = tbl_q[lookup_id_i];
  assign table_o  = tbl_q;

endmodule

// File: rtl/cvxif_issue_arbiter.sv
// Shares one CV-X-IF coprocessor between NumReq requesters: round-robin issue
// arbitration with grant lock, ID-indexed owner tracking, result steering and
// commit-kill release.
// Optional feature macro: CVXIF_ARB_ID_CHECK_EN (ID-busy masking + sticky err_o).
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ARB_IDLE   | grant chosen combinationally from rr_q among eligible requesters
// ARB_LOCKED | offer stalled by coprocessor; grant frozen in gnt_q until ready
module cvxif_issue_arbiter
  import cvxif_pkg::*;
#(
  parameter int unsigned NumReq = XNumReq
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  cvxif_issue_arbiter_if.slave  bus,
  output logic                  err_o
);

  localparam int unsigned GW = XOwnerWidth;

  arb_state_e   state_q;
  logic [GW-1:0] gnt_q, rr_q;

  logic [NumReq-1:0] elig;
  logic [GW-1:0]     win, gnt, res_owner;
  logic [GW:0]       sum;
  logic              win_found, issue_valid, issue_hs, res_hs;
  logic [NumReq-1:0] kill_own;
  logic [NumReq:0]   clr_en;
  x_id_t [NumReq:0]  clr_id;
  owner_entry_t      res_entry;
  owner_entry_t [XNumIds-1:0] tbl;

  // Requester eligibility; with ID checking a busy issue ID is masked out.
  always_comb begin
    elig = bus.req_issue_valid_i;
`ifdef CVXIF_ARB_ID_CHECK_EN
    for (int r = 0; r < NumReq; r++) begin
      if (tbl[bus.req_issue_req_i[r].id].valid) elig[r] = 1'b0;
    end
`endif
  end

  // Round-robin pick: first eligible requester at or after rr_q.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    sum       = '0;
    for (int i = 0; i < NumReq; i++) begin
      sum = {1'b0, rr_q} + (GW+1)'(i);
      if (sum >= (GW+1)'(NumReq)) sum = sum - (GW+1)'(NumReq);
      if (!win_found && elig[sum[GW-1:0]]) begin
        win_found = 1'b1;
        win       = sum[GW-1:0];
      end
    end
  end

  assign gnt         = (state_q == ARB_LOCKED) ? gnt_q : win;
  assign issue_valid = (state_q == ARB_LOCKED) | win_found;
  assign issue_hs    = issue_valid & bus.cop_issue_ready_i;

  // Issue path: forward granted payload, reflect ready/resp to the winner only.
  always_comb begin
    bus.cop_issue_valid_o = issue_valid;
    bus.cop_issue_req_o   = bus.req_issue_req_i[gnt];
    bus.req_issue_ready_o = '0;
    bus.req_issue_resp_o  = '0;
    if (issue_valid) begin
      bus.req_issue_ready_o[gnt] = bus.cop_issue_ready_i;
      bus.req_issue_resp_o[gnt]  = bus.cop_issue_resp_i;
    end
  end

  // Result path: steer valid to the recorded owner (owner 0 if entry invalid).
  assign res_owner = res_entry.valid ? res_entry.owner : '0;
  always_comb begin
    bus.req_result_valid_o            = '0;
    bus.req_result_valid_o[res_owner] = bus.cop_result_valid_i;
    bus.cop_result_ready_o            = bus.req_result_ready_i[res_owner];
    bus.req_result_o                  = bus.cop_result_i;
  end
  assign res_hs = bus.cop_result_valid_i & bus.cop_result_ready_o;

  // Clear ports: one per requester kill (owner-checked), last one for results.
  always_comb begin
    for (int r = 0; r < NumReq; r++) begin
      kill_own[r] = tbl[bus.req_kill_id_i[r]].valid &&
                    (tbl[bus.req_kill_id_i[r]].owner == GW'(r));
      clr_en[r]   = bus.req_kill_valid_i[r] & kill_own[r];
      clr_id[r]   = bus.req_kill_id_i[r];
    end
    clr_en[NumReq] = res_hs;
    clr_id[NumReq] = bus.cop_result_i.id;
  end

  cvxif_owner_table #(
    .NumClr (NumReq + 1)
  ) u_owner_table (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .set_en_i    (issue_hs & bus.cop_issue_resp_i.accept),
    .set_id_i    (bus.cop_issue_req_o.id),
    .set_owner_i (gnt),
    .clr_en_i    (clr_en),
    .clr_id_i    (clr_id),
    .lookup_id_i (bus.cop_result_i.id),
    .lookup_o    (res_entry),
    .table_o     (tbl)
  );

  // Arbiter FSM with grant lock and round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (win_found && !bus.cop_issue_ready_i) begin
            state_q <= ARB_LOCKED;
            gnt_q   <= win;
          end
        end
        ARB_LOCKED: begin
          if (bus.cop_issue_ready_i) state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
      if (issue_hs) rr_q <= rr_next(gnt, NumReq);
    end
  end

`ifdef CVXIF_ARB_ID_CHECK_EN
  logic err_q, err_ev;

  assign err_ev = (bus.cop_result_valid_i & ~res_entry.valid) |
                  (|(bus.req_kill_valid_i & ~kill_own)) |
                  ((state_q == ARB_LOCKED) & ~bus.req_issue_valid_i[gnt_q]);

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_q | err_ev;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: doc/cvxif_issue_arbiter.md
# cvxif_issue_arbiter

Shares one CV-X-IF coprocessor issue/result datapath between `NumReq` requesting cores or issue ports. Issue requests are arbitrated round-robin with a grant lock, and each accepted instruction's owner is recorded in an ID-indexed table. Results are steered back to the owning requester, and table entries are released on result handshake or commit kill. The block sits between the cores' CV-X-IF issue/result ports and the single coprocessor instance.

## Interface
- `NumReq`, 2, number of requesters (2..8)
- `IdWidth`, 3, instruction ID width; the owner table has 2**IdWidth entries
- `DataWidth`, 32, result data width (XLEN)
- `clk_i`  in  1  clock, all state on rising edge
- `rst_ni`  in  1  asynchronous active-low reset
- `req_issue_valid_i`  in  NumReq  per-requester issue valid
- `req_issue_ready_o`  out  NumReq  per-requester issue ready
- `req_issue_req_i`  in  NumReq x x_issue_req_t  per-requester issue payload (id, instr, rs)
- `req_issue_resp_o`  out  NumReq x x_issue_resp_t  accept/writeback, valid only for the granted requester
- `req_kill_valid_i`  in  NumReq  per-requester commit kill strobe
- `req_kill_id_i`  in  NumReq x IdWidth  ID being killed
- `req_result_valid_o`  out  NumReq  routed result valid
- `req_result_ready_i`  in  NumReq  requester result ready
- `req_result_o`  out  x_result_t  result payload, broadcast to all requesters
- `cop_issue_valid_o`, `cop_issue_ready_i`, `cop_issue_req_o`, `cop_issue_resp_i`  coprocessor issue port
- `cop_result_valid_i`, `cop_result_ready_o`, `cop_result_i`  coprocessor result port
- `err_o`  out  1  sticky protocol error (see Configuration)

## Operation
- Arbiter FSM has two states.
  - IDLE: picks the first valid requester at or after `rr_ptr`, drives `cop_issue_valid_o`=1 and forwards its payload.
  - LOCKED: entered when `cop_issue_valid_o` is high and `cop_issue_ready_i` is low. Grant is frozen until the handshake, even if the winner deasserts valid, which is a protocol violation (see Configuration). The FSM then returns to IDLE.
- Issue handshake: `req_issue_ready_o[g] = cop_issue_ready_i` for the granted requester g; all other requesters see 0. `req_issue_resp_o[g] = cop_issue_resp_i`; all other requesters see zeros.
- On handshake:
  - `rr_ptr` ← g+1 mod NumReq.
  - If `cop_issue_resp_i.accept`, the owner table entry at `id` is set to {valid=1, owner=g}.
  - If not accepted, the table is unchanged.
- Result routing:
  - owner = table[`cop_result_i.id`].
  - `req_result_valid_o[owner] = cop_result_valid_i`; all other bits are 0.
  - `cop_result_ready_o = req_result_ready_i[owner]`.
  - `req_result_o = cop_result_i`.
- Result handshake clears the table entry at that ID.
- Kill: `req_kill_valid_i[r]` clears `table[req_kill_id_i[r]]` only if its owner == r; otherwise it is ignored. Multiple kills in the same cycle are all applied.

## Timing
- Issue and result paths are combinational (0-cycle latency). Table updates are visible the next cycle.
- Reset values:
  - all `_valid_o` / `_ready_o` outputs 0
  - `err_o` 0
  - `rr_ptr` 0
  - FSM in IDLE
  - every table entry invalid
- Same-cycle set and clear on one ID (issue plus result or kill): clear is applied first, then set, so the entry ends owned by the new issuer.
- Result and kill on the same ID in the same cycle: a single clear.
- Result arriving for an invalid entry: routed to owner 0 with data forwarded, and flagged as an error under Configuration.
- `rr_ptr` wraps from NumReq-1 to 0.
- Reset asserted mid-lock drops the grant immediately (asynchronous reset).

## Configuration
- `CVXIF_ARB_ID_CHECK_EN` defined:
  - A requester whose issue ID maps to a valid table entry is masked from arbitration until that entry clears.
  - `err_o` is set, and held until reset, on any of:
    - a result for an invalid ID
    - a kill of an ID not owned by the killing requester
    - the winner deasserting valid in LOCKED
- Not defined: no ID masking; `err_o` is tied to 0.

## Structure
- `cvxif_pkg` holds `x_issue_req_t`, `x_issue_resp_t` and `x_result_t`.
- A new owner-entry struct `{logic valid; logic [$clog2(NumReq)-1:0] owner;}` also goes in `cvxif_pkg`.
- One sub-module, `cvxif_owner_table`: flop array with one set port and NumReq+1 clear ports, plus a combinational lookup port.

## Test plan
- R0 and R1 issue back-to-back with `cop_issue_ready_i`=1 → grants alternate R0, R1, R0; `rr_ptr` toggles.
- R1 issues id=5 while `cop_issue_ready_i` is low for 3 cycles, and R0 raises valid in cycle 2 → grant stays R1 until the handshake in cycle 4; R0 is served in cycle 5.
- R0 issues id=2 (accepted), then the coprocessor returns a result with id=2 and data=0x1234 → only `req_result_valid_o[0]` is high; a stall on `req_result_ready_i[0]` propagates to `cop_result_ready_o`.
- R1 issues id=3, R1 kills id=3, then R0 issues id=3 → with the macro, R0 is blocked until the kill cycle and granted the cycle after; the entry ends owner=0.
- Result for id=6 with no valid entry, macro defined → `err_o` rises the next cycle and stays high until `rst_ni` is pulsed.
- Result handshake on id=4 in the same cycle as a new accepted issue of id=4 by R1 → the entry is valid with owner=1 the next cycle.
